rr_arb_n: RTL and testbench
===========================

// Module: rr_arb_n
// PURPOSE
//   Parametrised N-way round-robin arbiter with a registered grant index, one-hot grant and valid flag.
//   Adds owner lock with a bounded quantum (forced preemption) and a clock-enable for rate-matched buses.
//   Sits between multiple producers (capture/SDRAM/USB paths) and a single shared resource port.
// PARAMETERS
//   NREQ     3   number of requesters, >= 2
//   IDXW     (NREQ>2 ? $clog2(NREQ) : 1)   width of grant index; derived, do not override
//   QUANTUM  16  max consecutive locked ce-cycles before preemption if others wait; 0 = unlimited
// PORTS
//   clk          in   1     clock; all state on rising edge
//   rst_n        in   1     asynchronous, active-low reset
//   ce           in   1     clock enable; state advances only when 1
//   req          in   NREQ  request vector, bit i = requester i
//   lock         in   1     current owner asks to keep grant (sampled only with req[grant])
//   grant        out  IDXW  index of current owner
//   grant_oh     out  NREQ  one-hot of grant, all-zero when grant_valid=0
//   grant_valid  out  1     grant is held by an active requester
//   preempt      out  1     one-cycle pulse: quantum expiry forced a grant change
// BEHAVIOUR
//   - Reset (async, immediate): grant=0, grant_oh=0, grant_valid=0, preempt=0, qcnt=0, state=IDLE.
//   - All outputs registered; 1 ce-cycle latency from req to grant. ce=0: every register holds, preempt->0.
//   - Search order from current grant g: g+1, g+2, ..., g+NREQ-1, then g (mod NREQ). winner = first set req bit.
//   - States: IDLE (grant_valid=0), OWNED (grant_valid=1).
//   - IDLE, ce: no req -> stay, grant unchanged. any req -> grant=winner, OWNED, qcnt=0.
//   - OWNED, ce, per cycle:
//       req[g]=1 & lock=1 & (QUANTUM=0 | qcnt<QUANTUM-1 | no other req) -> keep g, qcnt++ (saturate).
//       req[g]=1 & lock=1 & qcnt>=QUANTUM-1 & other req -> grant=next other requester, qcnt=0, preempt=1.
//       lock=0 or req[g]=0 -> grant=winner (g may re-win only if no other req), qcnt=0 if grant changes.
//       no req at all -> IDLE, grant holds last value (rotation pointer preserved).
//   - lock ignored when req[g]=0; lock never blocks arbitration from IDLE.
//   - Simultaneous requests: strictly rotating fairness; no requester waits more than
//     (NREQ-1) grants; with locks, at most (NREQ-1)*QUANTUM ce-cycles.
//   - Wrap-around: index NREQ-1 -> 0; grant never holds a value >= NREQ.
//   - Reset mid-lock: ownership dropped; after release arbitration restarts from index 0 order (1,2,..,0).
// CONFIGURATION
//   RR_ARB_PRIO_EN defined: extra input prio [NREQ] (in). If any req&prio bit set, the search considers
//     only req&prio bits (same rotating order); else plain req. A locked owner is still preempted only by
//     quantum expiry, and only in favour of a prio requester if any exist.
//   Undefined: no prio port; pure round-robin as above.
// STRUCTURE
//   Package rr_arb_pkg: state encoding constants (ST_IDLE, ST_OWNED), idx-width function.
//   Sub-module rr_pick: combinational rotate-and-find-first (inputs req mask, start index; outputs
//     index, found). Instantiated twice: full search and "others only" search (mask bit g cleared).
//   Top: state reg, grant reg, qcnt reg (width $clog2(QUANTUM+1)), preempt reg, one-hot decode from reg.
// TESTING
//   reset then req=3'b001 one ce -> grant=0, grant_oh=001, grant_valid=1; req=0 -> valid=0, grant=0.
//   req=3'b111, lock=0, ce=1 for 6 cycles from grant=0 -> grant sequence 1,2,0,1,2,0.
//   grant=1, req=3'b011, lock=1, QUANTUM=4 -> holds 1 for 4 ce-cycles, then grant=0 with preempt=1 for 1 cycle.
//   ce toggled 1,0,1 with req=3'b110 from grant=0 -> grant 1, hold 1 during ce=0, then 2.
//   rst_n asserted mid-lock (grant=2, valid=1) -> all outputs 0 same cycle without clk; after release req=111 -> grant=1.
//   RR_ARB_PRIO_EN: req=111, prio=100, from grant=0 -> grant=2 repeatedly; prio=000 -> resumes 0,1,2.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and
// parameter-derived width helpers.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Grant index width; a 2-way arbiter still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Quantum counter width; must hold values 0..q, minimum one bit.
    function automatic int qcnt_width(input int q);
        return (q < 1) ? 1 : $clog2(q + 1);
    endfunction

endpackage

// File: rtl/rr_arb_n_pick.sv
// Rotate-and-find-first: scans mask starting one past 'start', wrapping,
// and finishing on 'start' itself. Purely combinational.
module rr_arb_n_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    logic [IDXW-1:0] cand;

    // First set bit in rotating order start+1, ..., start+NREQ-1, start.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = start;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_n.sv
// N-way round-robin arbiter with owner lock, bounded quantum and clock enable.
// Optional macro RR_ARB_PRIO_EN adds a 'prio' input that restricts the search
// to prioritised requesters whenever any of them is requesting.
module rr_arb_n
    import rr_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int IDXW    = idx_width(NREQ),
    parameter int QUANTUM = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [NREQ-1:0] req,
`ifdef RR_ARB_PRIO_EN
    input  logic [NREQ-1:0] prio,
`endif
    input  logic            lock,
    output logic [IDXW-1:0] grant,
    output logic [NREQ-1:0] grant_oh,
    output logic            grant_valid,
    output logic            preempt
);

    localparam int QW = qcnt_width(QUANTUM);
    localparam logic [QW-1:0] Q_MAX  = QW'(QUANTUM);
    localparam logic [QW-1:0] Q_LAST = (QUANTUM > 0) ? QW'(QUANTUM - 1) : '0;

    arb_state_t      state;
    logic [IDXW-1:0] grant_r;
    logic [QW-1:0]   qcnt;

    logic [NREQ-1:0] own_bit;
    logic [NREQ-1:0] others_raw;
    logic [NREQ-1:0] full_mask;
    logic [NREQ-1:0] oth_mask;
    logic [IDXW-1:0] full_idx;
    logic [IDXW-1:0] oth_idx;
    logic            full_found;
    logic            oth_found;
    logic            others_any;
    logic            quantum_hit;

    assign own_bit    = NREQ'(1) << grant_r;
    assign others_raw = req & ~own_bit;
    assign others_any = |others_raw;

`ifdef RR_ARB_PRIO_EN
    logic [NREQ-1:0] req_hp;
    logic [NREQ-1:0] oth_hp;
    assign req_hp    = req & prio;
    assign oth_hp    = others_raw & prio;
    assign full_mask = (|req_hp) ? req_hp : req;
    assign oth_mask  = (|oth_hp) ? oth_hp : others_raw;
`else
    assign full_mask = req;
    assign oth_mask  = others_raw;
`endif

    // The owner may be preempted once it has used QUANTUM consecutive cycles.
    assign quantum_hit = (QUANTUM != 0) && (qcnt >= Q_LAST);

    rr_arb_n_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_full (
        .mask  (full_mask),
        .start (grant_r),
        .idx   (full_idx),
        .found (full_found)
    );

    rr_arb_n_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_oth (
        .mask  (oth_mask),
        .start (grant_r),
        .idx   (oth_idx),
        .found (oth_found)
    );

    // Arbitration state, grant pointer, quantum counter and preempt pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            grant_r <= '0;
            qcnt    <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (ce) begin
                case (state)
                    ST_IDLE: begin
                        if (full_found) begin
                            grant_r <= full_idx;
                            qcnt    <= '0;
                            state   <= ST_OWNED;
                        end
                    end
                    ST_OWNED: begin
                        if (!full_found) begin
                            // grant_r keeps the rotation pointer while idle
                            state <= ST_IDLE;
                        end else if (req[grant_r] && lock) begin
                            if (quantum_hit && others_any && oth_found) begin
                                grant_r <= oth_idx;
                                qcnt    <= '0;
                                preempt <= 1'b1;
                            end else if (qcnt != Q_MAX) begin
                                qcnt <= qcnt + 1'b1;
                            end
                        end else begin
                            grant_r <= full_idx;
                            if (full_idx != grant_r) begin
                                qcnt <= '0;
                            end else if (qcnt != Q_MAX) begin
                                qcnt <= qcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign grant       = grant_r;
    assign grant_valid = (state == ST_OWNED);
    assign grant_oh    = grant_valid ? own_bit : '0;

endmodule

// File: tb/tb_rr_arb_n.sv
// Directed bench for rr_arb_n (NREQ=3, QUANTUM=4); the prio steps are built
// only when RR_ARB_PRIO_EN is defined.
module tb_rr_arb_n;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [2:0] req;
    logic       lock;
    logic [1:0] grant;
    logic [2:0] grant_oh;
    logic       grant_valid;
    logic       preempt;
`ifdef RR_ARB_PRIO_EN
    logic [2:0] prio;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    rr_arb_n #(.NREQ(3), .QUANTUM(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .req         (req),
`ifdef RR_ARB_PRIO_EN
        .prio        (prio),
`endif
        .lock        (lock),
        .grant       (grant),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] eg, input logic [2:0] eoh,
                       input logic ev, input logic ep);
        cmp({tag, ".grant"},    32'(grant),       32'(eg));
        cmp({tag, ".grant_oh"}, 32'(grant_oh),    32'(eoh));
        cmp({tag, ".valid"},    32'(grant_valid), 32'(ev));
        cmp({tag, ".preempt"},  32'(preempt),     32'(ep));
    endtask

    // one rising edge, then sample on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        req   = 3'b000;
        lock  = 1'b0;
`ifdef RR_ARB_PRIO_EN
        prio  = 3'b000;
`endif
        tick();
        tick();
        chk("reset", 2'd0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // single requester then drop
        ce  = 1'b1;
        req = 3'b001;
        tick(); chk("single_req0", 2'd0, 3'b001, 1'b1, 1'b0);
        req = 3'b000;
        tick(); chk("drop_idle", 2'd0, 3'b000, 1'b0, 1'b0);

        // full rotation, no lock
        req = 3'b111;
        tick(); chk("rot1", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("rot2", 2'd2, 3'b100, 1'b1, 1'b0);
        tick(); chk("rot3", 2'd0, 3'b001, 1'b1, 1'b0);
        tick(); chk("rot4", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("rot5", 2'd2, 3'b100, 1'b1, 1'b0);
        tick(); chk("rot6", 2'd0, 3'b001, 1'b1, 1'b0);

        // locked owner 1 preempted after quantum of 4
        req = 3'b010;
        tick(); chk("q_acq", 2'd1, 3'b010, 1'b1, 1'b0);
        req  = 3'b011;
        lock = 1'b1;
        tick(); chk("q_hold1", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("q_hold2", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("q_hold3", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("q_preempt", 2'd0, 3'b001, 1'b1, 1'b1);
        tick(); chk("q_after", 2'd0, 3'b001, 1'b1, 1'b0);

        // clock enable gating
        lock = 1'b0;
        req  = 3'b110;
        tick(); chk("ce_on1", 2'd1, 3'b010, 1'b1, 1'b0);
        ce = 1'b0;
        tick(); chk("ce_off", 2'd1, 3'b010, 1'b1, 1'b0);
        ce = 1'b1;
        tick(); chk("ce_on2", 2'd2, 3'b100, 1'b1, 1'b0);

        // idle keeps pointer at 2; next search wraps to 0
        req = 3'b000;
        tick(); chk("idle_ptr", 2'd2, 3'b000, 1'b0, 1'b0);
        req = 3'b011;
        tick(); chk("wrap", 2'd0, 3'b001, 1'b1, 1'b0);

        // lone locked owner exceeds quantum without preemption
        req  = 3'b001;
        lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); chk("lone_lock", 2'd0, 3'b001, 1'b1, 1'b0);
        end
        req = 3'b011;
        tick(); chk("sat_preempt", 2'd1, 3'b010, 1'b1, 1'b1);

        // reset in the middle of a lock on index 2
        lock = 1'b0;
        req  = 3'b100;
        tick(); chk("ml_acq", 2'd2, 3'b100, 1'b1, 1'b0);
        lock = 1'b1;
        tick(); chk("ml_hold", 2'd2, 3'b100, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 2'd0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        lock  = 1'b0;
        req   = 3'b111;
        tick(); chk("post_rst", 2'd1, 3'b010, 1'b1, 1'b0);

`ifdef RR_ARB_PRIO_EN
        prio = 3'b100;
        tick(); chk("prio1", 2'd2, 3'b100, 1'b1, 1'b0);
        tick(); chk("prio2", 2'd2, 3'b100, 1'b1, 1'b0);
        tick(); chk("prio3", 2'd2, 3'b100, 1'b1, 1'b0);
        prio = 3'b000;
        tick(); chk("noprio0", 2'd0, 3'b001, 1'b1, 1'b0);
        tick(); chk("noprio1", 2'd1, 3'b010, 1'b1, 1'b0);
        tick(); chk("noprio2", 2'd2, 3'b100, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
